// File: rtl/sn_pkg.sv
// Shared types, field widths and byte-encoding helpers for the SN76489 write sequencer.
// The optional redundant-write shadow in sn_write_sequencer is enabled by SN_SKIP_REDUNDANT_EN.
package sn_pkg;

    localparam int CHAN_W = 2;
    localparam int DATA_W = 10;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic {
        KIND_TONE = 1'b0,
        KIND_VOL  = 1'b1
    } kind_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

    // Channel 3 with the tone/ctrl kind addresses the noise control register.
    function automatic logic sn_is_noise(input logic [CHAN_W-1:0] chan, input kind_t kind);
        return (chan == 2'd3) && (kind == KIND_TONE);
    endfunction

    function automatic logic sn_two_byte(input logic [CHAN_W-1:0] chan, input kind_t kind);
        return (kind == KIND_TONE) && (chan != 2'd3);
    endfunction

    function automatic logic [DATA_W-1:0] sn_mask_data(input logic [CHAN_W-1:0] chan,
                                                       input kind_t kind,
                                                       input logic [DATA_W-1:0] data);
        if (kind == KIND_VOL)
            return {6'b0, data[3:0]};
        else if (sn_is_noise(chan, kind))
            return {7'b0, data[2:0]};
        else
            return data;
    endfunction

    function automatic logic [BYTE_W-1:0] sn_latch_byte(input logic [CHAN_W-1:0] chan,
                                                        input kind_t kind,
                                                        input logic [DATA_W-1:0] data);
        logic [3:0] low;
        low = sn_is_noise(chan, kind) ? {1'b0, data[2:0]} : data[3:0];
        return {1'b1, chan, logic'(kind), low};
    endfunction

    function automatic logic [BYTE_W-1:0] sn_data_byte(input logic [DATA_W-1:0] data);
        return {2'b00, data[9:4]};
    endfunction

    // Volume registers occupy slots 0..3, tone slots 4..6, noise slot 7.
    function automatic logic [2:0] sn_shadow_idx(input logic [CHAN_W-1:0] chan, input kind_t kind);
        return {logic'(kind == KIND_TONE), chan};
    endfunction

endpackage

// File: rtl/sn_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N_REQ requests, search starts after the last winner.
module sn_rr_arbiter
    import sn_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = ptr;
        cand  = (ptr == LAST) ? '0 : ptr + 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && en && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
            cand = (cand == LAST) ? '0 : cand + 1'b1;
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge CLK) begin
        if (RST)
            ptr <= LAST;
        else if (found)
            ptr <= gidx;
    end

endmodule

// File: rtl/sn_write_sequencer.sv
// SN76489 bus-write sequencer: arbitrates requesters, encodes latch/data bytes, paces nWE by READY.
// Define SN_SKIP_REDUNDANT_EN to drop commands that match the last completed write to a register.
module sn_write_sequencer
    import sn_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int STROBE_CYC    = 4,
    parameter int READY_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*2-1:0]    req_chan,
    input  logic [N_REQ-1:0]      req_kind,
    input  logic [N_REQ*10-1:0]   req_data,
    output logic [7:0]            D,
    output logic                  nWE,
    output logic                  nCE,
    input  logic                  READY,
    output logic                  busy,
    output logic                  timeout_err
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CHAN_W-1:0]   chan_q;
    kind_t               kind_q;
    logic [DATA_W-1:0]   data_q;
    logic                second_q;

    logic [N_REQ-1:0]    grant;
    logic                arb_en;
    logic [CHAN_W-1:0]   sel_chan;
    kind_t               sel_kind;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   sel_masked;
    logic                sel_redundant;

    // Block a fresh grant during the accept-pulse cycle so a still-high valid is not re-granted.
    assign arb_en = (state == ST_IDLE) && !(|req_ready);
    assign busy   = (state != ST_IDLE);

    sn_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant)
    );

    always_comb begin
        sel_chan = '0;
        sel_kind = KIND_TONE;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_chan = req_chan[i*CHAN_W +: CHAN_W];
                sel_kind = kind_t'(req_kind[i]);
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        sel_masked = sn_mask_data(sel_chan, sel_kind, sel_data);
    end

`ifdef SN_SKIP_REDUNDANT_EN
    logic [DATA_W-1:0] shadow_val [8];
    logic [7:0]        shadow_vld;
    logic [2:0]        sel_idx;
    logic [2:0]        cur_idx;

    assign sel_idx       = sn_shadow_idx(sel_chan, sel_kind);
    assign cur_idx       = sn_shadow_idx(chan_q, kind_q);
    assign sel_redundant = shadow_vld[sel_idx] && (shadow_val[sel_idx] == sel_masked);

    // Shadow records what the core holds after each fully completed command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_vld <= '0;
        end else if (state == ST_HOLD && !second_q) begin
            shadow_vld[cur_idx] <= 1'b1;
            shadow_val[cur_idx] <= data_q;
        end
    end
`else
    assign sel_redundant = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            chan_q      <= '0;
            kind_q      <= KIND_TONE;
            data_q      <= '0;
            second_q    <= 1'b0;
            req_ready   <= '0;
            D           <= '0;
            nWE         <= 1'b1;
            nCE         <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        req_ready <= grant;
                        chan_q    <= sel_chan;
                        kind_q    <= sel_kind;
                        data_q    <= sel_masked;
                        second_q  <= sn_two_byte(sel_chan, sel_kind);
                        if (!sel_redundant) begin
                            state <= ST_SETUP;
                            D     <= sn_latch_byte(sel_chan, sel_kind, sel_masked);
                            nCE   <= 1'b0;
                            nWE   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    nWE   <= 1'b0;
                    cnt   <= '0;
                end
                ST_STROBE: begin
                    if (cnt == CNT_W'(STROBE_CYC - 1)) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (READY) begin
                        state <= ST_HOLD;
                        nWE   <= 1'b1;
                        nCE   <= 1'b1;
                    end else if (cnt == CNT_W'(READY_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        nWE         <= 1'b1;
                        nCE         <= 1'b1;
                        second_q    <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (second_q) begin
                        second_q <= 1'b0;
                        state    <= ST_SETUP;
                        D        <= sn_data_byte(data_q);
                        nCE      <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    nWE   <= 1'b1;
                    nCE   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_write_sequencer.sv
// Directed self-checking bench for sn_write_sequencer (default build; SN_SKIP_REDUNDANT_EN adds a skip test).
module tb_sn_write_sequencer;

    localparam int N_REQ         = 2;
    localparam int STROBE_CYC    = 4;
    localparam int READY_TIMEOUT = 255;

    logic                CLK = 1'b0;
    logic                RST;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*2-1:0]  req_chan;
    logic [N_REQ-1:0]    req_kind;
    logic [N_REQ*10-1:0] req_data;
    logic [7:0]          D;
    logic                nWE;
    logic                nCE;
    logic                READY;
    logic                busy;
    logic                timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    sn_write_sequencer #(
        .N_REQ         (N_REQ),
        .STROBE_CYC    (STROBE_CYC),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_chan    (req_chan),
        .req_kind    (req_kind),
        .req_data    (req_data),
        .D           (D),
        .nWE         (nWE),
        .nCE         (nCE),
        .READY       (READY),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic set_req(input int i, input logic [1:0] ch, input logic k, input logic [9:0] d);
        req_chan[i*2 +: 2]   = ch;
        req_kind[i]          = k;
        req_data[i*10 +: 10] = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        READY     = 1'b1;
        req_valid = '0;
        req_chan  = '0;
        req_kind  = '0;
        req_data  = '0;
        repeat (2) @(negedge CLK);
        checks++; if (D !== 8'h00) begin failures++; $display("[TB] FAIL reset_D got=%h exp=00", D); end
        checks++; if (nWE !== 1'b1) begin failures++; $display("[TB] FAIL reset_nWE got=%b exp=1", nWE); end
        checks++; if (nCE !== 1'b1) begin failures++; $display("[TB] FAIL reset_nCE got=%b exp=1", nCE); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // Two-byte tone write: latch 0xA5 then data 0x2A, each with nWE low STROBE_CYC+1 cycles.
    task automatic test_tone();
        logic [7:0] bytes [4];
        int lowlen [4];
        int nb = 0, pulses = 0, ncebad = 0, busycyc = 0;
        logic prev_we = 1'b1;
        for (int j = 0; j < 4; j++) begin bytes[j] = 8'h00; lowlen[j] = 0; end
        READY = 1'b1;
        set_req(0, 2'd1, 1'b0, 10'h2A5);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (req_ready[0]) begin pulses++; req_valid[0] = 1'b0; end
            if (nWE == 1'b0) begin
                if (prev_we && nb < 4) begin bytes[nb] = D; nb++; end
                if (nb > 0) lowlen[nb-1]++;
                if (nCE !== 1'b0) ncebad++;
            end
            prev_we = nWE;
            if (busy) busycyc++;
        end
        checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL tone_ready_pulses got=%0d exp=1", pulses); end
        checks++; if (nb != 2) begin failures++; $display("[TB] FAIL tone_byte_count got=%0d exp=2", nb); end
        checks++; if (bytes[0] !== 8'hA5) begin failures++; $display("[TB] FAIL tone_latch_byte got=%h exp=a5", bytes[0]); end
        checks++; if (bytes[1] !== 8'h2A) begin failures++; $display("[TB] FAIL tone_data_byte got=%h exp=2a", bytes[1]); end
        checks++; if (lowlen[0] != STROBE_CYC + 1) begin failures++; $display("[TB] FAIL tone_strobe0_len got=%0d exp=%0d", lowlen[0], STROBE_CYC + 1); end
        checks++; if (lowlen[1] != STROBE_CYC + 1) begin failures++; $display("[TB] FAIL tone_strobe1_len got=%0d exp=%0d", lowlen[1], STROBE_CYC + 1); end
        checks++; if (ncebad != 0) begin failures++; $display("[TB] FAIL tone_nce_during_we got=%0d exp=0", ncebad); end
        checks++; if (busycyc != 2 * (3 + STROBE_CYC)) begin failures++; $display("[TB] FAIL tone_busy_cycles got=%0d exp=%0d", busycyc, 2 * (3 + STROBE_CYC)); end
    endtask

    // Single-byte volume write from requester 1; busy drops 7 cycles after the accept pulse.
    task automatic test_vol();
        logic busyhist [40];
        int kp = -1, nb = 0;
        logic [7:0] b0 = 8'h00;
        logic prev_we = 1'b1;
        READY = 1'b1;
        set_req(1, 2'd2, 1'b1, 10'h007);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (req_ready[1] && kp < 0) begin kp = c; req_valid[1] = 1'b0; end
            if (nWE == 1'b0 && prev_we) begin if (nb == 0) b0 = D; nb++; end
            prev_we = nWE;
            busyhist[c] = busy;
        end
        checks++; if (nb != 1) begin failures++; $display("[TB] FAIL vol_byte_count got=%0d exp=1", nb); end
        checks++; if (b0 !== 8'hD7) begin failures++; $display("[TB] FAIL vol_byte got=%h exp=d7", b0); end
        if (kp < 0 || kp + 7 >= 40) begin
            checks++; failures++;
            $display("[TB] FAIL vol_ready_pulse got=none exp=pulse");
        end else begin
            checks++; if (busyhist[kp+6] !== 1'b1) begin failures++; $display("[TB] FAIL vol_busy_at_6 got=%b exp=1", busyhist[kp+6]); end
            checks++; if (busyhist[kp+7] !== 1'b0) begin failures++; $display("[TB] FAIL vol_busy_at_7 got=%b exp=0", busyhist[kp+7]); end
        end
    endtask

    // READY held low: write aborts after the timeout, error is sticky until reset.
    task automatic test_timeout();
        int lowcnt = 0, early_err = 0;
        logic seen_low = 1'b0, done = 1'b0;
        READY = 1'b0;
        set_req(0, 2'd0, 1'b1, 10'h003);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge CLK);
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (nWE == 1'b0) begin
                seen_low = 1'b1;
                lowcnt++;
                if (timeout_err) early_err++;
            end else if (seen_low) begin
                done = 1'b1;
            end
        end
        checks++; if (!done) begin failures++; $display("[TB] FAIL timeout_abort got=no_abort exp=abort"); end
        checks++; if (lowcnt < STROBE_CYC + READY_TIMEOUT || lowcnt > STROBE_CYC + READY_TIMEOUT + 1) begin
            failures++; $display("[TB] FAIL timeout_low_len got=%0d exp=%0d..%0d", lowcnt, STROBE_CYC + READY_TIMEOUT, STROBE_CYC + READY_TIMEOUT + 1);
        end
        checks++; if (early_err != 0) begin failures++; $display("[TB] FAIL timeout_early_err got=%0d exp=0", early_err); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err_set got=%b exp=1", timeout_err); end
        checks++; if (nCE !== 1'b1) begin failures++; $display("[TB] FAIL timeout_nCE got=%b exp=1", nCE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy got=%b exp=0", busy); end
        READY = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err_sticky got=%b exp=1", timeout_err); end
    endtask

    // Reset pulsed during the first byte's strobe abandons the tone write.
    task automatic test_reset_mid();
        int ncelow = 0;
        logic hit = 1'b0;
        READY = 1'b1;
        set_req(0, 2'd1, 1'b0, 10'h2A5);
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge CLK);
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (nWE == 1'b0) hit = 1'b1;
        end
        checks++; if (!hit) begin failures++; $display("[TB] FAIL rstmid_strobe got=no_strobe exp=strobe"); end
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (nWE !== 1'b1 || nCE !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_strobes got=nWE%b/nCE%b exp=1/1", nWE, nCE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_timeout_err got=%b exp=0", timeout_err); end
        checks++; if (D !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_D got=%h exp=00", D); end
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (nCE == 1'b0) ncelow++;
        end
        checks++; if (ncelow != 0) begin failures++; $display("[TB] FAIL rstmid_no_second_byte got=%0d exp=0", ncelow); end
    endtask

    // Both requesters continuously valid: grants alternate starting with requester 0.
    task automatic test_back_to_back();
        int grants [6];
        int ng = 0, multi = 0;
        for (int j = 0; j < 6; j++) grants[j] = -1;
        READY = 1'b1;
        set_req(0, 2'd0, 1'b1, 10'h001);
        set_req(1, 2'd1, 1'b1, 10'h002);
        for (int c = 0; c < 200 && ng < 6; c++) begin
            @(negedge CLK);
            if (req_ready == 2'b11) multi++;
            if (req_ready[0] && ng < 6) begin grants[ng] = 0; ng++; end
            if (req_ready[1] && ng < 6) begin grants[ng] = 1; ng++; end
        end
        req_valid = '0;
        checks++; if (ng != 6) begin failures++; $display("[TB] FAIL rr_grant_count got=%0d exp=6", ng); end
        checks++; if (multi != 0) begin failures++; $display("[TB] FAIL rr_onehot got=%0d exp=0", multi); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (grants[j] != j % 2) begin failures++; $display("[TB] FAIL rr_order[%0d] got=%0d exp=%0d", j, grants[j], j % 2); end
        end
        repeat (20) @(negedge CLK);
    endtask

`ifdef SN_SKIP_REDUNDANT_EN
    // Repeated identical noise command is accepted without touching the bus.
    task automatic test_skip_redundant();
        int pulses = 0, ncelow = 0, nb = 0;
        logic [7:0] b0 = 8'h00;
        logic prev_we = 1'b1;
        READY = 1'b1;
        set_req(0, 2'd3, 1'b0, 10'h005);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (nWE == 1'b0 && prev_we) begin if (nb == 0) b0 = D; nb++; end
            prev_we = nWE;
        end
        checks++; if (b0 !== 8'hE5) begin failures++; $display("[TB] FAIL skip_first_byte got=%h exp=e5", b0); end
        set_req(0, 2'd3, 1'b0, 10'h005);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (req_ready[0]) begin pulses++; req_valid[0] = 1'b0; end
            if (nCE == 1'b0) ncelow++;
        end
        checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL skip_ready_pulse got=%0d exp=1", pulses); end
        checks++; if (ncelow != 0) begin failures++; $display("[TB] FAIL skip_no_bus got=%0d exp=0", ncelow); end
    endtask
`endif

    initial begin
        test_reset();
        test_tone();
        test_vol();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef SN_SKIP_REDUNDANT_EN
        test_skip_redundant();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
